nibble_packer: RTL

Downstream consumer of the 4-bit result bus produced by `mod1` (`OV1_3`). It samples a qualified 4-bit value each cycle and packs four consecutive nibbles into a 16-bit word. Completed words are buffered in a small first-word-fall-through FIFO and delivered over a valid/ready handshake. This adds the first clocked stage behind the purely combinational `mod1` hierarchy.

---
 rtl/nibble_packer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/nibble_packer.sv
// nibble_packer
//   Packs qualified 4-bit samples into NIBBLES-nibble words, first nibble in
//   the LSBs. Completed or flushed words are queued in a first-word-fall-
//   through FIFO and delivered over a valid/ready handshake.
//
// Ports
//   CLK       in   clock, all state changes on the rising edge
//   RST       in   synchronous active-high reset
//   IB_VALID  in   IV_DATA carries a sample this cycle
//   IV_DATA   in   4-bit sample
//   IB_FLUSH  in   push the current partial word, zero-padded
//   IB_READY  in   downstream takes OV_WORD this cycle
//   OB_VALID  out  FIFO non-empty
//   OV_WORD   out  FIFO head word, zero while OB_VALID is low
//   OB_OVF    out  sticky: a completed word was dropped on a full FIFO
//   OV_LEVEL  out  FIFO occupancy, 0..DEPTH
module nibble_packer #(
  parameter int DEPTH   = 4,
  parameter int NIBBLES = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IB_VALID,
  input  logic [3:0]                 IV_DATA,
  input  logic                       IB_FLUSH,
  input  logic                       IB_READY,
  output logic                       OB_VALID,
  output logic [4*NIBBLES-1:0]       OV_WORD,
  output logic                       OB_OVF,
  output logic [$clog2(DEPTH+1)-1:0] OV_LEVEL
);

  localparam int WW = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] LAST_COUNT = CW'(NIBBLES - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  // ---------------------------------------------------------------------
  // Packing stage
  // ---------------------------------------------------------------------
  logic [WW-1:0] partial_reg, partial_next;
  logic [CW-1:0] count_reg, count_next;
  logic [WW-1:0] word_assembled;
  logic          last_nibble;
  logic          has_data;
  logic          push;

  // The partial register is kept zero above the current count, so the word
  // including this cycle's nibble (if any) is already zero-padded and serves
  // both the natural completion and the flush case.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_lane
      assign word_assembled[4*gi +: 4] =
        (IB_VALID && count_reg == CW'(gi)) ? IV_DATA : partial_reg[4*gi +: 4];
    end
  endgenerate

  assign last_nibble = IB_VALID && (count_reg == LAST_COUNT);
  assign has_data    = IB_VALID || (count_reg != '0);
  // A flush on the completing nibble folds into the same single push.
  assign push        = last_nibble || (IB_FLUSH && has_data);

  always_comb begin
    partial_next = partial_reg;
    count_next   = count_reg;
    if (push) begin
      partial_next = '0;
      count_next   = '0;
    end else if (IB_VALID) begin
      partial_next = word_assembled;
      count_next   = count_reg + CW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [WW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg, level_next;
  logic          ovf_reg;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == FULL_LEVEL);
  assign pop     = !empty && IB_READY;
  // When full, the slot being popped this edge is the one written, so a
  // simultaneous pop makes room.
  assign push_ok = push && (!full || pop);

  always_comb begin
    level_next = level_reg;
    case ({push_ok, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      partial_reg <= '0;
      count_reg   <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      partial_reg <= partial_next;
      count_reg   <= count_next;
      level_reg   <= level_next;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push && !push_ok) ovf_reg <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (!RST && push_ok) mem[wr_ptr_reg] <= word_assembled;
  end

  assign OB_VALID = !empty;
  assign OV_WORD  = empty ? '0 : mem[rd_ptr_reg];
  assign OB_OVF   = ovf_reg;
  assign OV_LEVEL = level_reg;

endmodule
